retire_trace_buffer: RTL and testbench

Retirement trace buffer sitting directly downstream of the RV32 core's write-back stage. It samples the per-instruction retire record (valid, pc, imm, rs1n/rs2n/rdn, Exception) every cycle, tags each record with a sequence number and queues it in a FIFO. Records drain to a trace consumer over a valid/ready stream. On the first retired exception the block captures that record exactly once, ignores the core's frozen retire outputs and halts.

---
 rtl/retire_trace_buffer_if.sv | 31 +++
 rtl/retire_trace_buffer.sv | 158 +++++++++++++++
 tb/tb_retire_trace_buffer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : retire_trace_buffer_if
//  Brief    : Retire-record input bus plus valid/ready trace output stream.
//  Revision : 1.0  initial release
// ============================================================================
interface retire_trace_buffer_if;
   logic        ret_valid;
   logic        ret_exception;
   logic [31:0] ret_pc;
   logic [31:0] ret_imm;
   logic [4:0]  ret_rs1n;
   logic [4:0]  ret_rs2n;
   logic [4:0]  ret_rdn;
   logic        trc_valid;
   logic        trc_ready;
   logic [95:0] trc_data;

   modport master (
      output ret_valid, ret_exception, ret_pc, ret_imm, ret_rs1n, ret_rs2n, ret_rdn,
      output trc_ready,
      input  trc_valid, trc_data
   );

   modport slave (
      input  ret_valid, ret_exception, ret_pc, ret_imm, ret_rs1n, ret_rs2n, ret_rdn,
      input  trc_ready,
      output trc_valid, trc_data
   );
endinterface
`default_nettype wire

// File: rtl/retire_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : retire_trace_buffer
//  Brief    : Sequence-tagged retire-record FIFO that halts after the first
//             retired exception has been delivered.
//  Revision : 1.0  initial release
// ============================================================================
module retire_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   retire_trace_buffer_if.slave bus,
   output logic [LW-1:0]        level,
   output logic                 overflow,
   output logic [15:0]          drop_count,
   output logic                 halted
);
   localparam int            c_AW   = $clog2(DEPTH);
   localparam logic [LW-1:0] c_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] c_ONE  = LW'(1);

   typedef enum logic [1:0] {
      S_RUN       = 2'd0,
      S_HALT_PEND = 2'd1,
      S_HALTED    = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [95:0]       r_mem [DEPTH];
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [LW-1:0]     r_count;
   logic              r_pend_valid;
   logic [95:0]       r_pend_data;
   logic [15:0]       r_seq;
   logic [15:0]       r_drop_count;
   logic              r_overflow;

   logic              w_nonempty;
   logic              w_pop;
   logic              w_slot;
   logic              w_push;
   logic [95:0]       w_push_data;
   logic              w_drop;
   logic              w_pend_load;
   logic              w_pend_clear;
   logic              w_seq_inc;
   logic [95:0]       w_ret_rec;

   assign w_nonempty = (r_count != '0);
   assign w_pop      = w_nonempty & bus.trc_ready;
   // A pop in the same cycle frees the slot the push lands in.
   assign w_slot     = (r_count != c_FULL) | w_pop;
   assign w_ret_rec  = {r_seq, bus.ret_exception, bus.ret_rdn, bus.ret_rs2n,
                        bus.ret_rs1n, bus.ret_imm, bus.ret_pc};

   assign bus.trc_valid = w_nonempty;
   assign bus.trc_data  = w_nonempty ? r_mem[r_rd_ptr] : '0;
   assign level         = r_count + LW'(r_pend_valid);
   assign overflow      = r_overflow;
   assign drop_count    = r_drop_count;
   assign halted        = (r_state == S_HALTED);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_push       = 1'b0;
      w_push_data  = w_ret_rec;
      w_drop       = 1'b0;
      w_pend_load  = 1'b0;
      w_pend_clear = 1'b0;
      w_seq_inc    = 1'b0;
      case (r_state)
         S_RUN: begin
            if (bus.ret_valid) begin
               w_seq_inc = 1'b1;
               w_push    = w_slot;
               if (bus.ret_exception) begin
                  w_state_nxt = S_HALT_PEND;
                  w_pend_load = ~w_slot;
               end else begin
                  w_drop = ~w_slot;
               end
            end
         end
         S_HALT_PEND: begin
            // Frozen core outputs are ignored here; only the held record moves.
            if (r_pend_valid && w_slot) begin
               w_push       = 1'b1;
               w_push_data  = r_pend_data;
               w_pend_clear = 1'b1;
            end
            if (w_pop && (r_count == c_ONE) && !r_pend_valid) begin
               w_state_nxt = S_HALTED;
            end
         end
         S_HALTED: w_state_nxt = S_HALTED;
         default:  w_state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_pend_valid <= 1'b0;
         r_pend_data  <= '0;
         r_seq        <= '0;
         r_drop_count <= '0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_ONE;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - c_ONE;
         end
         if (w_pend_load) begin
            r_pend_valid <= 1'b1;
            r_pend_data  <= w_ret_rec;
         end else if (w_pend_clear) begin
            r_pend_valid <= 1'b0;
         end
         if (w_seq_inc) begin
            r_seq <= r_seq + 16'd1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) begin
               r_drop_count <= r_drop_count + 16'd1;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_retire_trace_buffer
//  Brief    : Directed scenarios plus randomized traffic against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_retire_trace_buffer;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [LW-1:0] level;
   logic          overflow;
   logic [15:0]   drop_count;
   logic          halted;

   retire_trace_buffer_if bus ();

   retire_trace_buffer #(.DEPTH(DEPTH), .LW(LW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .level      (level),
      .overflow   (overflow),
      .drop_count (drop_count),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: a queue of records plus a held exception record.
   logic [95:0] m_q [$];
   logic        m_pend_v;
   logic [95:0] m_pend;
   logic [15:0] m_seq;
   logic [15:0] m_drops;
   logic        m_ovf;
   logic        m_halt_pend;
   logic        m_halted;
   logic        m_exc_seen;

   function automatic logic [95:0] mk_rec(input logic [15:0] seq, input logic exc,
                                          input logic [4:0] rdn, input logic [4:0] rs2n,
                                          input logic [4:0] rs1n, input logic [31:0] imm,
                                          input logic [31:0] pc);
      return {seq, exc, rdn, rs2n, rs1n, imm, pc};
   endfunction

   task automatic m_reset();
      m_q.delete();
      m_pend_v    = 1'b0;
      m_pend      = '0;
      m_seq       = '0;
      m_drops     = '0;
      m_ovf       = 1'b0;
      m_halt_pend = 1'b0;
      m_halted    = 1'b0;
      m_exc_seen  = 1'b0;
   endtask

   task automatic m_step();
      logic        pop;
      logic        free;
      logic [95:0] r;
      pop  = (m_q.size() != 0) && bus.trc_ready;
      free = (m_q.size() < DEPTH) || pop;
      if (pop) begin
         r = m_q.pop_front();
         if (r[79]) m_exc_seen = 1'b1;
      end
      if (!m_halt_pend && !m_halted && bus.ret_valid) begin
         r = mk_rec(m_seq, bus.ret_exception, bus.ret_rdn, bus.ret_rs2n,
                    bus.ret_rs1n, bus.ret_imm, bus.ret_pc);
         m_seq = m_seq + 16'd1;
         if (bus.ret_exception) begin
            m_halt_pend = 1'b1;
            if (free) m_q.push_back(r);
            else begin
               m_pend_v = 1'b1;
               m_pend   = r;
            end
         end else if (free) begin
            m_q.push_back(r);
         end else begin
            m_ovf = 1'b1;
            if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
         end
      end else if (m_halt_pend && m_pend_v && free) begin
         m_q.push_back(m_pend);
         m_pend_v = 1'b0;
      end
      if (m_halt_pend && m_q.size() == 0 && !m_pend_v && m_exc_seen) begin
         m_halt_pend = 1'b0;
         m_halted    = 1'b1;
      end
   endtask

   task automatic tick();
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic e, input logic [31:0] pc);
      bus.ret_valid     = v;
      bus.ret_exception = e;
      bus.ret_pc        = pc;
      bus.ret_imm       = $urandom;
      bus.ret_rs1n      = 5'($urandom);
      bus.ret_rs2n      = 5'($urandom);
      bus.ret_rdn       = 5'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0);
      bus.trc_ready = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.trc_valid !== 1'b0) begin failures++; $display("FAIL reset_trc_valid got=%0b exp=0", bus.trc_valid); end
      checks++; if (bus.trc_data !== 96'h0) begin failures++; $display("FAIL reset_trc_data got=%h exp=0", bus.trc_data); end
      checks++; if (level !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
      checks++; if (drop_count !== 16'h0) begin failures++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
   endtask

   task automatic test_basic();
      logic [95:0] exp;
      do_reset();
      bus.trc_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'(i * 4));
         exp = mk_rec(16'(i), 1'b0, bus.ret_rdn, bus.ret_rs2n, bus.ret_rs1n, bus.ret_imm, bus.ret_pc);
         tick();
         checks++; if (bus.trc_valid !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d] got=%0b exp=1", i, bus.trc_valid); end
         checks++; if (bus.trc_data !== exp) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, bus.trc_data, exp); end
         checks++; if (level !== LW'(1)) begin failures++; $display("FAIL basic_level[%0d] got=%0d exp=1", i, level); end
      end
      drive(1'b0, 1'b0, 32'h0);
      tick();
      checks++; if (level !== '0 || bus.trc_valid !== 1'b0) begin failures++; $display("FAIL basic_drained level=%0d valid=%0b exp level=0 valid=0", level, bus.trc_valid); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 32'(i * 4));
         tick();
      end
      drive(1'b0, 1'b0, 32'h0);
      checks++; if (level !== LW'(16)) begin failures++; $display("FAIL ovf_level got=%0d exp=16", level); end
      checks++; if (drop_count !== 16'd4) begin failures++; $display("FAIL ovf_drop_count got=%0d exp=4", drop_count); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_overflow got=%0b exp=1", overflow); end
      bus.trc_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({bus.trc_valid, bus.trc_data[95:80], bus.trc_data[31:0]} !== {1'b1, 16'(i), 32'(i * 4)}) begin
            failures++;
            $display("FAIL ovf_drain[%0d] got valid=%0b seq=%0d pc=%h exp valid=1 seq=%0d pc=%h",
                     i, bus.trc_valid, bus.trc_data[95:80], bus.trc_data[31:0], i, i * 4);
         end
         tick();
      end
      bus.trc_ready = 1'b0;
      checks++; if (level !== '0) begin failures++; $display("FAIL ovf_drained_level got=%0d exp=0", level); end
      drive(1'b1, 1'b0, 32'h100);
      tick();
      drive(1'b0, 1'b0, 32'h0);
      checks++; if (bus.trc_data[95:80] !== 16'd20) begin failures++; $display("FAIL ovf_next_seq got=%0d exp=20", bus.trc_data[95:80]); end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 32'(i * 4));
         tick();
      end
      drive(1'b1, 1'b0, 32'h200);
      bus.trc_ready = 1'b1;
      tick();
      drive(1'b0, 1'b0, 32'h0);
      bus.trc_ready = 1'b0;
      checks++; if (level !== LW'(16)) begin failures++; $display("FAIL fullpop_level got=%0d exp=16", level); end
      checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL fullpop_drop got=%0d ovf=%0b exp=0 ovf=0", drop_count, overflow); end
      checks++; if (bus.trc_data[95:80] !== 16'd1) begin failures++; $display("FAIL fullpop_head_seq got=%0d exp=1", bus.trc_data[95:80]); end
   endtask

   task automatic test_exception_hold();
      logic [95:0] exp;
      do_reset();
      bus.trc_ready = 1'b1;
      drive(1'b1, 1'b1, 32'h40);
      exp = mk_rec(16'd0, 1'b1, bus.ret_rdn, bus.ret_rs2n, bus.ret_rs1n, bus.ret_imm, bus.ret_pc);
      tick();
      checks++; if (bus.trc_valid !== 1'b1 || bus.trc_data !== exp) begin failures++; $display("FAIL exc_record got valid=%0b data=%h exp valid=1 data=%h", bus.trc_valid, bus.trc_data, exp); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL exc_halted_early got=%0b exp=0", halted); end
      drive(1'b1, 1'b1, 32'h44);
      tick();
      checks++; if (halted !== 1'b1 || level !== '0 || bus.trc_valid !== 1'b0) begin failures++; $display("FAIL exc_halt got halted=%0b level=%0d valid=%0b exp 1/0/0", halted, level, bus.trc_valid); end
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b1, 32'h44);
         tick();
         checks++; if (halted !== 1'b1 || level !== '0 || bus.trc_valid !== 1'b0) begin failures++; $display("FAIL exc_frozen[%0d] got halted=%0b level=%0d valid=%0b exp 1/0/0", i, halted, level, bus.trc_valid); end
      end
   endtask

   task automatic test_full_exception();
      logic [95:0] exp;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 32'(i * 4));
         tick();
      end
      drive(1'b1, 1'b1, 32'h80);
      exp = mk_rec(16'd16, 1'b1, bus.ret_rdn, bus.ret_rs2n, bus.ret_rs1n, bus.ret_imm, bus.ret_pc);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 32'h84);
         tick();
      end
      checks++; if (level !== LW'(17)) begin failures++; $display("FAIL fexc_level got=%0d exp=17", level); end
      checks++; if (drop_count !== 16'd0 || overflow !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL fexc_flags got drops=%0d ovf=%0b halted=%0b exp 0/0/0", drop_count, overflow, halted); end
      bus.trc_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         checks++;
         if (bus.trc_valid !== 1'b1 || bus.trc_data[95:80] !== 16'(i)) begin
            failures++;
            $display("FAIL fexc_drain[%0d] got valid=%0b seq=%0d exp valid=1 seq=%0d", i, bus.trc_valid, bus.trc_data[95:80], i);
         end
         if (i == 16) begin
            checks++; if (bus.trc_data !== exp) begin failures++; $display("FAIL fexc_last got=%h exp=%h", bus.trc_data, exp); end
         end
         drive(1'b1, 1'b1, 32'h84);
         tick();
      end
      checks++; if (halted !== 1'b1 || level !== '0 || bus.trc_valid !== 1'b0) begin failures++; $display("FAIL fexc_halt got halted=%0b level=%0d valid=%0b exp 1/0/0", halted, level, bus.trc_valid); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 32'(i * 4));
         tick();
      end
      drive(1'b1, 1'b1, 32'h90);
      tick();
      drive(1'b1, 1'b1, 32'h94);
      checks++; if (level !== LW'(9)) begin failures++; $display("FAIL arst_pre_level got=%0d exp=9", level); end
      #2;
      rst = 1'b0;
      m_reset();
      #1;
      checks++;
      if ({bus.trc_valid, bus.trc_data, level, overflow, drop_count, halted} !== '0) begin
         failures++;
         $display("FAIL arst_outputs got valid=%0b data=%h level=%0d ovf=%0b drops=%0d halted=%0b exp all 0",
                  bus.trc_valid, bus.trc_data, level, overflow, drop_count, halted);
      end
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 1'b0, 32'h300);
      tick();
      drive(1'b0, 1'b0, 32'h0);
      checks++; if (bus.trc_valid !== 1'b1 || bus.trc_data[95:80] !== 16'd0 || level !== LW'(1)) begin failures++; $display("FAIL arst_next got valid=%0b seq=%0d level=%0d exp 1/0/1", bus.trc_valid, bus.trc_data[95:80], level); end
   endtask

   task automatic test_random();
      int          bias [4] = '{95, 50, 15, 100};
      logic [95:0] exp_data;
      logic [LW-1:0] exp_level;
      for (int ep = 0; ep < 4; ep++) begin
         do_reset();
         for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 99) < 80, $urandom_range(0, 149) == 0, $urandom);
            bus.trc_ready = ($urandom_range(0, 99) < bias[ep]);
            tick();
            exp_data  = (m_q.size() != 0) ? m_q[0] : 96'h0;
            exp_level = LW'(m_q.size() + int'(m_pend_v));
            checks++; if (bus.trc_valid !== (m_q.size() != 0)) begin failures++; $display("FAIL rnd_valid ep%0d c%0d got=%0b exp=%0b", ep, c, bus.trc_valid, m_q.size() != 0); end
            checks++; if (bus.trc_data !== exp_data) begin failures++; $display("FAIL rnd_data ep%0d c%0d got=%h exp=%h", ep, c, bus.trc_data, exp_data); end
            checks++; if (level !== exp_level) begin failures++; $display("FAIL rnd_level ep%0d c%0d got=%0d exp=%0d", ep, c, level, exp_level); end
            checks++; if (drop_count !== m_drops || overflow !== m_ovf) begin failures++; $display("FAIL rnd_drops ep%0d c%0d got=%0d/%0b exp=%0d/%0b", ep, c, drop_count, overflow, m_drops, m_ovf); end
            checks++; if (halted !== m_halted) begin failures++; $display("FAIL rnd_halted ep%0d c%0d got=%0b exp=%0b", ep, c, halted, m_halted); end
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_full_pop();
      test_exception_hold();
      test_full_exception();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
